// File: rtl/key_lock_pkg.sv
// Shared definitions for the key lock unit: load/check FSM state encoding
// and the total key width derivation.
package key_lock_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CHECK = 3'd2,
    ARMED = 3'd3,
    ERROR = 3'd4
  } state_e;

  // Total key bits: one per XOR gate plus four per 4:1 mux channel.
  function automatic int unsigned key_w(input int unsigned data_w,
                                        input int unsigned mux_ch);
    return data_w + 4 * mux_ch;
  endfunction

endpackage

// File: rtl/key_lock_unit_if.sv
// Bus bundle for key_lock_unit.
//   key_start/key_valid/key_bit -> serial key load (master drives)
//   key_ready/key_armed/key_err <- load status (slave drives)
//   in_valid/data_in/mux_sel    -> locked data path input
//   out_valid/data_out/mux_out  <- locked data path output, 1-cycle latency
interface key_lock_unit_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned MUX_CH = 1
) ();

  logic                  key_start;
  logic                  key_valid;
  logic                  key_bit;
  logic                  key_ready;
  logic                  key_armed;
  logic                  key_err;
  logic                  in_valid;
  logic [DATA_W-1:0]     data_in;
  logic [2*MUX_CH-1:0]   mux_sel;
  logic                  out_valid;
  logic [DATA_W-1:0]     data_out;
  logic [MUX_CH-1:0]     mux_out;

  modport master (
    output key_start, key_valid, key_bit, in_valid, data_in, mux_sel,
    input  key_ready, key_armed, key_err, out_valid, data_out, mux_out
  );

  modport slave (
    input  key_start, key_valid, key_bit, in_valid, data_in, mux_sel,
    output key_ready, key_armed, key_err, out_valid, data_out, mux_out
  );

endinterface

// File: rtl/key_shift_loader.sv
// Serial key shift register with bit counter and running parity.
//   clk, rst_n  clock, async active-low reset
//   clear_i     synchronous clear of key, count and parity
//   accept_i    key_bit_i is consumed this cycle
//   bit_i       serial bit, key LSB first, parity bit last
//   key_o       assembled key
//   count_o     number of key bits shifted in (saturates at KEY_W)
//   parity_o    XOR of every accepted bit, parity bit included
module key_shift_loader #(
  parameter int unsigned KEY_W = 12
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear_i,
  input  logic                         accept_i,
  input  logic                         bit_i,
  output logic [KEY_W-1:0]             key_o,
  output logic [$clog2(KEY_W+1)-1:0]   count_o,
  output logic                         parity_o
);

  localparam int unsigned CNT_W = $clog2(KEY_W + 1);
  localparam logic [CNT_W-1:0] KEY_W_C = CNT_W'(KEY_W);

  logic [KEY_W-1:0] key_q;
  logic [CNT_W-1:0] count_q;
  logic             parity_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q    <= '0;
      count_q  <= '0;
      parity_q <= 1'b0;
    end else if (clear_i) begin
      key_q    <= '0;
      count_q  <= '0;
      parity_q <= 1'b0;
    end else if (accept_i) begin
      parity_q <= parity_q ^ bit_i;
      // Once KEY_W bits are in, the next bit is parity only: it feeds the
      // accumulator but leaves the key untouched.
      if (count_q < KEY_W_C) begin
        key_q   <= {bit_i, key_q[KEY_W-1:1]};
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  assign key_o    = key_q;
  assign count_o  = count_q;
  assign parity_o = parity_q;

endmodule

// File: rtl/key_lock_unit.sv
// Sequential key lock: serially loaded, parity-checked key register driving
// a DATA_W-bit XOR key-gate bank and MUX_CH key-selected 4:1 mux channels.
//   clk, rst_n  clock, async active-low reset
//   bus         key_lock_unit_if.slave (key load + locked data path)
// Outputs are forced to zero while no valid key is armed.
module key_lock_unit
  import key_lock_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned MUX_CH = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  key_lock_unit_if.slave  bus
);

  localparam int unsigned KEY_W = key_w(DATA_W, MUX_CH);
  localparam int unsigned CNT_W = $clog2(KEY_W + 1);
  localparam logic [CNT_W-1:0] KEY_W_C = CNT_W'(KEY_W);

  state_e              state_q;
  logic                key_ready_q;
  logic                key_armed_q;
  logic                key_err_q;
  logic                out_valid_q;
  logic [DATA_W-1:0]   data_out_q;
  logic [MUX_CH-1:0]   mux_out_q;

  logic [KEY_W-1:0]    key;
  logic [CNT_W-1:0]    count;
  logic                parity;
  logic                accept;
  logic                parity_last;
  logic                bad_check;
  logic [MUX_CH-1:0]   mux_d;

  // key_start wins over a simultaneous key_valid: that bit is dropped.
  assign accept      = bus.key_valid & key_ready_q & ~bus.key_start;
  assign parity_last = accept && (count == KEY_W_C);
  assign bad_check   = (state_q == CHECK) && parity;

  key_shift_loader #(
    .KEY_W(KEY_W)
  ) u_loader (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear_i  (bus.key_start | bad_check),
    .accept_i (accept),
    .bit_i    (bus.key_bit),
    .key_o    (key),
    .count_o  (count),
    .parity_o (parity)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      key_ready_q <= 1'b0;
      key_armed_q <= 1'b0;
      key_err_q   <= 1'b0;
    end else if (bus.key_start) begin
      state_q     <= LOAD;
      key_ready_q <= 1'b1;
      key_armed_q <= 1'b0;
      key_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        LOAD: begin
          if (parity_last) begin
            state_q     <= CHECK;
            key_ready_q <= 1'b0;
          end
        end
        CHECK: begin
          // Even parity: accumulated XOR over key + parity bit must be 0.
          if (parity) begin
            state_q   <= ERROR;
            key_err_q <= 1'b1;
          end else begin
            state_q     <= ARMED;
            key_armed_q <= 1'b1;
          end
        end
        ARMED: ;
        ERROR: ;
        default: begin
          state_q     <= IDLE;
          key_ready_q <= 1'b0;
          key_armed_q <= 1'b0;
        end
      endcase
    end
  end

  // Channel c selects one of key[DATA_W+4c +: 4] by mux_sel[2c+1:2c].
  for (genvar c = 0; c < MUX_CH; c++) begin : g_mux
    logic [3:0] grp;
    assign grp      = key[DATA_W + 4*c +: 4];
    assign mux_d[c] = grp[bus.mux_sel[2*c +: 2]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      data_out_q  <= '0;
      mux_out_q   <= '0;
    end else begin
      out_valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        data_out_q <= key_armed_q ? (bus.data_in ^ key[DATA_W-1:0]) : '0;
        mux_out_q  <= key_armed_q ? mux_d : '0;
      end
    end
  end

  assign bus.key_ready = key_ready_q;
  assign bus.key_armed = key_armed_q;
  assign bus.key_err   = key_err_q;
  assign bus.out_valid = out_valid_q;
  assign bus.data_out  = data_out_q;
  assign bus.mux_out   = mux_out_q;

endmodule

// File: tb/tb_key_lock_unit.sv
// Directed bench for key_lock_unit with DATA_W=8, MUX_CH=1 (KEY_W=12).
module tb_key_lock_unit;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  key_lock_unit_if #(.DATA_W(8), .MUX_CH(1)) bus ();

  key_lock_unit #(.DATA_W(8), .MUX_CH(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       vld;
    logic [7:0] din;
    logic [1:0] sel;
    logic [7:0] exp_data;
    logic       exp_mux;
    logic       exp_ov;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse();
    bus.key_start = 1'b1;
    tick();
    bus.key_start = 1'b0;
  endtask

  // Shift k LSB first then parity bit p; gapped=1 inserts i%4 idle cycles.
  task automatic load_bits(input logic [11:0] k, input logic p, input bit gapped);
    for (int i = 0; i < 13; i++) begin
      if (gapped) repeat (i % 4) tick();
      bus.key_valid = 1'b1;
      bus.key_bit   = (i == 12) ? p : k[i];
      tick();
      bus.key_valid = 1'b0;
    end
  endtask

  // Called right after the parity bit edge: CHECK cycle, then outcome.
  task automatic check_outcome(input string name, input logic exp_armed, input logic exp_err);
    check({name, "_chk_ready"}, 32'(bus.key_ready), 32'd0);
    check({name, "_chk_armed"}, 32'(bus.key_armed), 32'd0);
    tick();
    check({name, "_armed"}, 32'(bus.key_armed), 32'(exp_armed));
    check({name, "_err"},   32'(bus.key_err),   32'(exp_err));
    check({name, "_ready"}, 32'(bus.key_ready), 32'd0);
  endtask

  task automatic data_xfer(input string name, input logic [7:0] din, input logic [1:0] sel,
                           input logic [7:0] exp_d, input logic exp_m);
    bus.in_valid = 1'b1;
    bus.data_in  = din;
    bus.mux_sel  = sel;
    tick();
    bus.in_valid = 1'b0;
    check({name, "_ov"},   32'(bus.out_valid), 32'd1);
    check({name, "_data"}, 32'(bus.data_out),  32'(exp_d));
    check({name, "_mux"},  32'(bus.mux_out),   32'(exp_m));
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ready"}, 32'(bus.key_ready), 32'd0);
    check({name, "_armed"}, 32'(bus.key_armed), 32'd0);
    check({name, "_err"},   32'(bus.key_err),   32'd0);
    check({name, "_ov"},    32'(bus.out_valid), 32'd0);
    check({name, "_data"},  32'(bus.data_out),  32'd0);
    check({name, "_mux"},   32'(bus.mux_out),   32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.key_start = 1'b0;
    bus.key_valid = 1'b0;
    bus.key_bit   = 1'b0;
    bus.in_valid  = 1'b0;
    bus.data_in   = '0;
    bus.mux_sel   = '0;

    // Key 12'h6A5: xor byte A5, mux nibble 6 = 4'b0110 -> sel 0..3 gives 0,1,1,0.
    vecs[0] = '{1'b1, 8'h0F, 2'b01, 8'hAA, 1'b1, 1'b1};
    vecs[1] = '{1'b1, 8'hFF, 2'b00, 8'h5A, 1'b0, 1'b1};
    vecs[2] = '{1'b1, 8'h00, 2'b11, 8'hA5, 1'b0, 1'b1};
    vecs[3] = '{1'b1, 8'hA5, 2'b10, 8'h00, 1'b1, 1'b1};
    vecs[4] = '{1'b0, 8'h33, 2'b00, 8'h00, 1'b1, 1'b0};  // hold previous outputs
    vecs[5] = '{1'b1, 8'h5A, 2'b01, 8'hFF, 1'b1, 1'b1};

    repeat (2) tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Good load: 12'h6A5 has six ones, so the even-parity bit is 0.
    start_pulse();
    check("load_ready", 32'(bus.key_ready), 32'd1);
    load_bits(12'h6A5, 1'b0, 1'b0);
    check_outcome("good", 1'b1, 1'b0);

    for (int i = 0; i < 6; i++) begin
      bus.in_valid = vecs[i].vld;
      bus.data_in  = vecs[i].din;
      bus.mux_sel  = vecs[i].sel;
      tick();
      check($sformatf("vec%0d_ov", i),   32'(bus.out_valid), 32'(vecs[i].exp_ov));
      check($sformatf("vec%0d_data", i), 32'(bus.data_out),  32'(vecs[i].exp_data));
      check($sformatf("vec%0d_mux", i),  32'(bus.mux_out),   32'(vecs[i].exp_mux));
    end
    bus.in_valid = 1'b0;

    // Reset mid-load: armed key still used on the key_start edge.
    bus.key_start = 1'b1;
    bus.in_valid  = 1'b1;
    bus.data_in   = 8'h0F;
    bus.mux_sel   = 2'b01;
    tick();
    bus.key_start = 1'b0;
    check("rs_edge_data", 32'(bus.data_out), 32'hAA);
    check("rs_disarm", 32'(bus.key_armed), 32'd0);
    for (int i = 0; i < 5; i++) begin
      bus.key_valid = 1'b1;
      bus.key_bit   = 1'b1;
      tick();
    end
    bus.key_valid = 1'b0;
    check("rs_ready_pre", 32'(bus.key_ready), 32'd1);
    check("rs_ov_pre",    32'(bus.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("rs_async");
    bus.in_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    start_pulse();
    load_bits(12'h6A5, 1'b0, 1'b0);
    check_outcome("rs_reload", 1'b1, 1'b0);
    data_xfer("rs_data", 8'h0F, 2'b01, 8'hAA, 1'b1);

    // Bad parity.
    start_pulse();
    load_bits(12'h6A5, 1'b1, 1'b0);
    check_outcome("bad", 1'b0, 1'b1);
    data_xfer("bad_data", 8'hFF, 2'b01, 8'h00, 1'b0);

    // Restart: key_start clears err; abort after 7 bits with a colliding bit.
    start_pulse();
    check("err_cleared", 32'(bus.key_err), 32'd0);
    for (int i = 0; i < 7; i++) begin
      bus.key_valid = 1'b1;
      bus.key_bit   = 1'b1;
      tick();
    end
    bus.key_start = 1'b1;
    bus.key_valid = 1'b1;
    bus.key_bit   = 1'b1;
    tick();
    bus.key_start = 1'b0;
    bus.key_valid = 1'b0;
    check("restart_ready", 32'(bus.key_ready), 32'd1);
    load_bits(12'h6A5, 1'b0, 1'b0);
    check_outcome("restart", 1'b1, 1'b0);
    data_xfer("restart_data", 8'h0F, 2'b01, 8'hAA, 1'b1);

    // Stalled load gives the same result.
    start_pulse();
    load_bits(12'h6A5, 1'b0, 1'b1);
    check_outcome("stall", 1'b1, 1'b0);
    data_xfer("stall_data", 8'h0F, 2'b10, 8'hAA, 1'b1);

    // Second key 12'h1F0: five ones -> parity 1; xor F0, mux nibble 4'b0001.
    start_pulse();
    load_bits(12'h1F0, 1'b1, 1'b1);
    check_outcome("k2", 1'b1, 1'b0);
    data_xfer("k2_a", 8'h0F, 2'b00, 8'hFF, 1'b1);
    data_xfer("k2_b", 8'h3C, 2'b11, 8'hCC, 1'b0);

    // Rearm: key_start while ARMED drops armed next cycle, outputs forced 0.
    bus.key_start = 1'b1;
    bus.in_valid  = 1'b1;
    bus.data_in   = 8'h0F;
    bus.mux_sel   = 2'b00;
    tick();
    bus.key_start = 1'b0;
    check("rearm_edge_data", 32'(bus.data_out), 32'hFF);
    check("rearm_armed", 32'(bus.key_armed), 32'd0);
    check("rearm_ready", 32'(bus.key_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    check("rearm_data", 32'(bus.data_out), 32'h00);
    check("rearm_mux",  32'(bus.mux_out),  32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
